// File: rtl/parity_fifo_v2.sv
// Parity-checked first-word-fall-through FIFO with arbitrary depth, occupancy thresholds,
// a saturating corrupt-word counter and sticky overflow/underflow flags.
module parity_fifo_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 1,
  parameter int ERR_MODE   = 0,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH:0]              push_data_i,
  input  logic                             push_valid_i,
  output logic                             push_grant_o,
  input  logic                             pop_grant_i,
  output logic [DATA_WIDTH:0]              pop_data_o,
  output logic                             pop_valid_o,
  output logic                             pop_err_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic [ERR_CNT_W-1:0]             err_cnt_o,
  output logic                             ovf_o,
  output logic                             udf_o,
  input  logic                             err_clr_i
);

  localparam int   W            = DATA_WIDTH + 1;
  localparam int   CW           = $clog2(FIFO_DEPTH + 1);
  localparam int   PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic LP_ODD       = (EVEN_ODD != 0);
  localparam logic LP_CHECK     = (PARITY_BIT != 0);
  localparam logic LP_STORE_BAD = (ERR_MODE != 0);

  logic [W-1:0]          r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_flag;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_full;
  logic w_empty;
  logic w_bad;
  logic w_push_fire;
  logic w_write;
  logic w_pop_fire;

  // Pointers wrap at the configured depth, not at a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_bad        = LP_CHECK & ((^push_data_i) != LP_ODD);
  assign push_grant_o = ~w_full & ~rst;
  assign w_push_fire  = push_valid_i & push_grant_o;
  assign w_write      = w_push_fire & (~w_bad | LP_STORE_BAD);
  assign pop_valid_o  = ~w_empty;
  assign w_pop_fire   = pop_grant_i & pop_valid_o;

  assign pop_data_o     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign pop_err_o      = LP_STORE_BAD & ~w_empty & r_flag[r_rd_ptr];
  assign count_o        = r_count;
  assign almost_full_o  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty_o = (r_count <= CW'(AE_LEVEL));
  assign err_cnt_o      = r_err_cnt;
  assign ovf_o          = r_ovf;
  assign udf_o          = r_udf;

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr]  <= push_data_i;
      r_flag[r_wr_ptr] <= w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_write)    r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_fire) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_write) - CW'(w_pop_fire);
      // Clear wins over any same-cycle set, but a corrupt push still counts once.
      if (err_clr_i) begin
        r_err_cnt <= (w_push_fire & w_bad) ? ERR_CNT_W'(1) : '0;
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
      end else begin
        if (w_push_fire & w_bad)          r_err_cnt <= sat_inc(r_err_cnt);
        if (push_valid_i & ~push_grant_o) r_ovf     <= 1'b1;
        if (pop_grant_i & ~pop_valid_o)   r_udf     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_fifo_v2.sv
// Bench for parity_fifo_v2: two instances (drop / store corrupt words) share one stimulus
// stream and are compared against a queue-based reference model, plus directed vectors.
module tb_parity_fifo_v2;

  logic       clk = 1'b0;
  logic       rst, pv, pg, clr;
  logic [8:0] pdata;

  logic       gnt_o [2];
  logic       vld_o [2];
  logic       perr_o [2];
  logic       af_o [2];
  logic       ae_o [2];
  logic       ovf_o [2];
  logic       udf_o [2];
  logic [8:0] pd_o [2];
  logic [2:0] cnt_o [2];
  logic [7:0] ec_o [2];

  int passed = 0;
  int total  = 0;

  // Reference model: per instance a queue of {err_flag, word}, plus counters/flags.
  logic [9:0] mq [2][$];
  int         m_ec [2];
  bit         m_ovf [2];
  bit         m_udf [2];

  always #5 clk = ~clk;

  parity_fifo_v2 #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .EVEN_ODD(0), .PARITY_BIT(1), .ERR_MODE(0))
  u_drop (
    .clk(clk), .rst(rst), .push_data_i(pdata), .push_valid_i(pv), .push_grant_o(gnt_o[0]),
    .pop_grant_i(pg), .pop_data_o(pd_o[0]), .pop_valid_o(vld_o[0]), .pop_err_o(perr_o[0]),
    .count_o(cnt_o[0]), .almost_full_o(af_o[0]), .almost_empty_o(ae_o[0]),
    .err_cnt_o(ec_o[0]), .ovf_o(ovf_o[0]), .udf_o(udf_o[0]), .err_clr_i(clr)
  );

  parity_fifo_v2 #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .EVEN_ODD(0), .PARITY_BIT(1), .ERR_MODE(1))
  u_store (
    .clk(clk), .rst(rst), .push_data_i(pdata), .push_valid_i(pv), .push_grant_o(gnt_o[1]),
    .pop_grant_i(pg), .pop_data_o(pd_o[1]), .pop_valid_o(vld_o[1]), .pop_err_o(perr_o[1]),
    .count_o(cnt_o[1]), .almost_full_o(af_o[1]), .almost_empty_o(ae_o[1]),
    .err_cnt_o(ec_o[1]), .ovf_o(ovf_o[1]), .udf_o(udf_o[1]), .err_clr_i(clr)
  );

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, m, act, exp, $time);
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int         n;
      logic [8:0] hd;
      logic       he;
      n  = mq[m].size();
      hd = (n != 0) ? mq[m][0][8:0] : 9'h000;
      he = (n != 0 && m == 1) ? mq[m][0][9] : 1'b0;
      chk("count",    m, 32'(cnt_o[m]),  32'(n));
      chk("pop_valid",m, 32'(vld_o[m]),  32'(n != 0));
      chk("pop_data", m, 32'(pd_o[m]),   32'(hd));
      chk("pop_err",  m, 32'(perr_o[m]), 32'(he));
      chk("grant",    m, 32'(gnt_o[m]),  32'(n < 5 && !rst));
      chk("afull",    m, 32'(af_o[m]),   32'(n >= 4));
      chk("aempty",   m, 32'(ae_o[m]),   32'(n <= 1));
      chk("err_cnt",  m, 32'(ec_o[m]),   32'(m_ec[m]));
      chk("ovf",      m, 32'(ovf_o[m]),  32'(m_ovf[m]));
      chk("udf",      m, 32'(udf_o[m]),  32'(m_udf[m]));
    end
  endtask

  // One clock: predict from pre-edge state and inputs, step the model, then compare.
  task automatic tick();
    bit grant [2];
    bit fire [2];
    bit popf [2];
    bit bad;
    bad = ^pdata;
    for (int m = 0; m < 2; m++) begin
      grant[m] = (mq[m].size() < 5) && !rst;
      fire[m]  = pv && grant[m];
      popf[m]  = pg && (mq[m].size() != 0);
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mq[m].delete();
        m_ec[m] = 0; m_ovf[m] = 0; m_udf[m] = 0;
      end else begin
        if (popf[m]) void'(mq[m].pop_front());
        if (fire[m] && (!bad || m == 1)) mq[m].push_back({bad, pdata});
        if (clr) begin
          m_ec[m] = (fire[m] && bad) ? 1 : 0;
          m_ovf[m] = 0; m_udf[m] = 0;
        end else begin
          if (fire[m] && bad && m_ec[m] < 255) m_ec[m]++;
          if (pv && !grant[m]) m_ovf[m] = 1;
          if (pg && !popf[m])  m_udf[m] = 1;
        end
      end
    end
    check_all();
  endtask

  function automatic logic [8:0] good_word(input logic [7:0] d);
    return {^d, d};
  endfunction

  typedef struct {
    logic       pv;
    logic [8:0] d;
    logic       pg;
    int         cnt;
    logic       vld;
    logic [8:0] dat;
    logic       gnt, ovf, udf, af, ae;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 9'h003, 1'b0, 1, 1'b1, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 9'h005, 1'b0, 2, 1'b1, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 9'h006, 1'b0, 3, 1'b1, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 9'h009, 1'b0, 4, 1'b1, 9'h003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 9'h00A, 1'b0, 5, 1'b1, 9'h003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 9'h00C, 1'b0, 5, 1'b1, 9'h003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 9'h000, 1'b1, 4, 1'b1, 9'h005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 9'h000, 1'b1, 3, 1'b1, 9'h006, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 9'h000, 1'b1, 2, 1'b1, 9'h009, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 9'h000, 1'b1, 1, 1'b1, 9'h00A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 9'h000, 1'b1, 0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 9'h000, 1'b1, 0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; pv = 1'b0; pg = 1'b0; clr = 1'b0; pdata = '0;
    @(posedge clk);
    tick();
    rst = 1'b0;

    // Fill past full, then drain past empty.
    for (int i = 0; i < 12; i++) begin
      pv = tbl[i].pv; pdata = tbl[i].d; pg = tbl[i].pg;
      tick();
      chk("tbl_count", 0, 32'(cnt_o[0]), 32'(tbl[i].cnt));
      chk("tbl_valid", 0, 32'(vld_o[0]), 32'(tbl[i].vld));
      chk("tbl_data",  0, 32'(pd_o[0]),  32'(tbl[i].dat));
      chk("tbl_grant", 0, 32'(gnt_o[0]), 32'(tbl[i].gnt));
      chk("tbl_ovf",   0, 32'(ovf_o[0]), 32'(tbl[i].ovf));
      chk("tbl_udf",   0, 32'(udf_o[0]), 32'(tbl[i].udf));
      chk("tbl_afull", 0, 32'(af_o[0]),  32'(tbl[i].af));
      chk("tbl_aempty",0, 32'(ae_o[0]),  32'(tbl[i].ae));
    end
    pv = 1'b0; pg = 1'b0;

    // Streaming push+pop for 12 cycles: pointers wrap twice, order preserved.
    for (int i = 0; i < 12; i++) begin
      pv = 1'b1; pg = 1'b1; pdata = good_word(8'(i * 7 + 1));
      if (i > 0) chk("wrap_head", 0, 32'(pd_o[0]), 32'(good_word(8'((i - 1) * 7 + 1))));
      tick();
    end
    pv = 1'b0;
    tick();
    pg = 1'b0;
    chk("wrap_drained", 0, 32'(cnt_o[0]), 32'(0));

    // Corrupt word dropped (ERR_MODE=0) versus stored and flagged (ERR_MODE=1).
    clr = 1'b1; tick(); clr = 1'b0;
    pv = 1'b1; pdata = 9'h001; tick();
    pdata = 9'h003; tick();
    pv = 1'b0;
    chk("drop_errcnt", 0, 32'(ec_o[0]), 32'(1));
    chk("drop_count",  0, 32'(cnt_o[0]), 32'(1));
    chk("drop_head",   0, 32'(pd_o[0]), 32'h003);
    chk("store_count", 1, 32'(cnt_o[1]), 32'(2));
    chk("store_head",  1, 32'(pd_o[1]), 32'h001);
    chk("store_err",   1, 32'(perr_o[1]), 32'(1));
    pg = 1'b1; tick(); pg = 1'b0;
    chk("drop_empty",  0, 32'(vld_o[0]), 32'(0));
    chk("store_next",  1, 32'(pd_o[1]), 32'h003);
    chk("store_noerr", 1, 32'(perr_o[1]), 32'(0));
    pv = 1'b1; pdata = 9'h001; tick();
    chk("errcnt_two",  1, 32'(ec_o[1]), 32'(2));
    clr = 1'b1; tick(); clr = 1'b0; pv = 1'b0;
    chk("clr_with_bad", 0, 32'(ec_o[0]), 32'(1));
    chk("clr_with_bad", 1, 32'(ec_o[1]), 32'(1));
    pg = 1'b1; repeat (4) tick(); pg = 1'b0;

    // Error counter saturation.
    pv = 1'b1; pg = 1'b1; pdata = 9'h001;
    repeat (260) tick();
    pv = 1'b0;
    chk("err_sat", 0, 32'(ec_o[0]), 32'(255));
    chk("err_sat", 1, 32'(ec_o[1]), 32'(255));
    repeat (3) tick();
    pg = 1'b0;

    // Mid-operation reset with three words held.
    pv = 1'b1;
    pdata = 9'h003; tick();
    pdata = 9'h005; tick();
    pdata = 9'h006; tick();
    pv = 1'b0;
    chk("pre_rst_count", 0, 32'(cnt_o[0]), 32'(3));
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("rst_count", 0, 32'(cnt_o[0]), 32'(0));
    chk("rst_valid", 0, 32'(vld_o[0]), 32'(0));
    chk("rst_grant", 0, 32'(gnt_o[0]), 32'(1));
    chk("rst_errcnt", 1, 32'(ec_o[1]), 32'(0));

    // Randomised traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      bit fill;
      fill  = ((i / 40) % 2) == 0;
      pv    = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      pg    = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      pdata = 9'($urandom_range(0, 511));
      clr   = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; pv = 1'b0; pg = 1'b0; clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
